// File: rtl/pe_fetch.sv
// Instruction fetch front-end: drives fetch addresses into busctl, captures read
// data after a fixed latency and queues {pc, word} in a prefetch FIFO for decode.
module pe_fetch #(
    parameter int unsigned     AD_LEN     = 32,
    parameter int unsigned     BUS_WIDTH  = 32,
    parameter logic [AD_LEN-1:0] RESET_PC = '0,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter int unsigned     BUS_LAT    = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    output logic [AD_LEN-1:0]    bus_ad_o,
    input  logic [BUS_WIDTH-1:0] bus_data_i,
    input  logic                 redirect_i,
    input  logic [AD_LEN-1:0]    redirect_pc_i,
    output logic [BUS_WIDTH-1:0] insn_o,
    output logic [AD_LEN-1:0]    insn_pc_o,
    output logic                 insn_valid_o,
    input  logic                 insn_ready_i
);

    localparam int unsigned BYTES = BUS_WIDTH / 8;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LAT_W = $clog2(BUS_LAT + 1);
    localparam int unsigned ENT_W = AD_LEN + BUS_WIDTH;

    typedef enum logic {FETCH, STALL} state_t;

    state_t            state_q, state_n;
    logic [AD_LEN-1:0] addr_n;
    logic [LAT_W-1:0]  lat_q, lat_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [PTR_W-1:0]  rd_q, rd_n, wr_q, wr_n;
    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [ENT_W-1:0]  push_ent, head_n;
    logic              push, pop, space, capture;

    assign push_ent = {bus_ad_o, bus_data_i};

    // Next-state: redirect flushes everything; otherwise capture, stall or count latency
    always_comb begin
        state_n = state_q;
        addr_n  = bus_ad_o;
        lat_n   = lat_q;
        cnt_n   = cnt_q;
        rd_n    = rd_q;
        wr_n    = wr_q;
        push    = 1'b0;
        head_n  = {insn_pc_o, insn_o};
        capture = (lat_q == LAT_W'(BUS_LAT));
        pop     = insn_valid_o && insn_ready_i;
        space   = (cnt_q != CNT_W'(FIFO_DEPTH)) || pop;

        if (redirect_i) begin
            state_n = FETCH;
            addr_n  = redirect_pc_i & ~AD_LEN'(BYTES - 1);
            lat_n   = '0;
            cnt_n   = '0;
            rd_n    = '0;
            wr_n    = '0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (capture) begin
                        if (space) push = 1'b1;
                        else       state_n = STALL;
                    end else begin
                        lat_n = lat_q + LAT_W'(1);
                    end
                end
                STALL: begin
                    if (space) begin
                        push    = 1'b1;
                        state_n = FETCH;
                    end
                end
            endcase

            if (push) begin
                addr_n = bus_ad_o + AD_LEN'(BYTES);
                lat_n  = '0;
                wr_n   = wr_q + PTR_W'(1);
            end
            if (pop) rd_n = rd_q + PTR_W'(1);
            cnt_n = cnt_q + CNT_W'(push) - CNT_W'(pop);

            // New head may be the word being pushed this very cycle
            if (cnt_n != '0) head_n = (push && (wr_q == rd_n)) ? push_ent : mem[rd_n];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= FETCH;
        else         state_q <= state_n;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bus_ad_o     <= RESET_PC;
            lat_q        <= '0;
            cnt_q        <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            insn_valid_o <= 1'b0;
            insn_o       <= '0;
            insn_pc_o    <= '0;
        end else begin
            bus_ad_o     <= addr_n;
            lat_q        <= lat_n;
            cnt_q        <= cnt_n;
            rd_q         <= rd_n;
            wr_q         <= wr_n;
            insn_valid_o <= (cnt_n != '0);
            insn_pc_o    <= head_n[ENT_W-1 -: AD_LEN];
            insn_o       <= head_n[BUS_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_q] <= push_ent;
    end

endmodule

// File: tb/tb_pe_fetch.sv
// Bench for pe_fetch: two instances (BUS_LAT 1 and 3) share random stimulus and are
// compared each cycle against a queue-style reference model of the fetch behaviour.
module tb_pe_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] PAT    = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst, redirect, ready;
    logic [31:0] rpc;
    logic [31:0] bus_ad [2];
    logic [31:0] bus_data [2];
    logic [31:0] insn [2];
    logic [31:0] insn_pc [2];
    logic        valid [2];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    assign bus_data[0] = bus_ad[0] ^ PAT;
    assign bus_data[1] = bus_ad[1] ^ PAT;

    pe_fetch #(.AD_LEN(32), .BUS_WIDTH(32), .RESET_PC(RST_PC), .FIFO_DEPTH(4), .BUS_LAT(1)) u_dut1 (
        .clk_i(clk), .reset_i(rst), .bus_ad_o(bus_ad[0]), .bus_data_i(bus_data[0]),
        .redirect_i(redirect), .redirect_pc_i(rpc), .insn_o(insn[0]), .insn_pc_o(insn_pc[0]),
        .insn_valid_o(valid[0]), .insn_ready_i(ready));

    pe_fetch #(.AD_LEN(32), .BUS_WIDTH(32), .RESET_PC(RST_PC), .FIFO_DEPTH(4), .BUS_LAT(3)) u_dut3 (
        .clk_i(clk), .reset_i(rst), .bus_ad_o(bus_ad[1]), .bus_data_i(bus_data[1]),
        .redirect_i(redirect), .redirect_pc_i(rpc), .insn_o(insn[1]), .insn_pc_o(insn_pc[1]),
        .insn_valid_o(valid[1]), .insn_ready_i(ready));

    // Reference model: in-order list of buffered words, oldest at index 0
    logic [31:0] m_addr [2];
    int          m_wait [2];
    logic [31:0] m_pc [2][4];
    logic [31:0] m_d [2][4];
    int          m_n [2];
    logic [31:0] m_hpc [2];
    logic [31:0] m_hd [2];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset(input int k);
        m_addr[k] = RST_PC;
        m_wait[k] = 0;
        m_n[k]    = 0;
        m_hpc[k]  = '0;
        m_hd[k]   = '0;
    endtask

    task automatic model_step(input int k);
        bit pop, data_ok, do_push;
        if (rst) begin
            model_reset(k);
            return;
        end
        pop = (m_n[k] != 0) && ready;
        if (redirect) begin
            m_n[k]    = 0;
            m_addr[k] = rpc & ~32'h3;
            m_wait[k] = 0;
            return;
        end
        data_ok = (m_wait[k] >= lat_of(k));
        do_push = data_ok && ((m_n[k] < 4) || pop);
        if (pop) begin
            for (int j = 0; j < 3; j++) begin
                m_pc[k][j] = m_pc[k][j+1];
                m_d[k][j]  = m_d[k][j+1];
            end
            m_n[k]--;
        end
        if (do_push) begin
            m_pc[k][m_n[k]] = m_addr[k];
            m_d[k][m_n[k]]  = m_addr[k] ^ PAT;
            m_n[k]++;
            m_addr[k] = m_addr[k] + 32'd4;
            m_wait[k] = 0;
        end else if (!data_ok) begin
            m_wait[k]++;
        end
        if (m_n[k] > 0) begin
            m_hpc[k] = m_pc[k][0];
            m_hd[k]  = m_d[k][0];
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("bus_ad[lat%0d]", lat_of(k)), bus_ad[k], m_addr[k]);
            check($sformatf("valid[lat%0d]", lat_of(k)), 32'(valid[k]), 32'(m_n[k] != 0));
            check($sformatf("insn_pc[lat%0d]", lat_of(k)), insn_pc[k], m_hpc[k]);
            check($sformatf("insn[lat%0d]", lat_of(k)), insn[k], m_hd[k]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Assert reset between clock edges; outputs must drop without waiting for an edge
    task automatic async_reset();
        rst = 1'b1;
        #2;
        for (int k = 0; k < 2; k++) model_reset(k);
        check_all();
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; ready = 1'b1; rpc = '0;
        #1;
        for (int k = 0; k < 2; k++) model_reset(k);
        check_all();
        run(2);
        rst = 1'b0;

        // Streaming with a ready consumer
        run(12);
        // Consumer stalls until FIFO full, then drains
        ready = 1'b0;
        run(20);
        ready = 1'b1;
        run(20);

        // Three buffered entries plus a capture in the redirect cycle (BUS_LAT=1 instance)
        rst = 1'b1;
        run(1);
        rst = 1'b0; ready = 1'b0;
        run(7);
        redirect = 1'b1; rpc = 32'h0000_2003;
        run(1);
        redirect = 1'b0; ready = 1'b1;
        run(16);

        // Back-to-back redirects, last one near the top of the address space
        redirect = 1'b1; rpc = 32'h0000_5554;
        run(1);
        rpc = 32'hFFFF_FFF8;
        run(1);
        redirect = 1'b0;
        run(16);

        // Random traffic with occasional redirects and mid-cycle resets
        for (int i = 0; i < 500; i++) begin
            ready    = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 15) == 0);
            rpc      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
            if ($urandom_range(0, 60) == 0) begin
                async_reset();
                run(1);
                rst = 1'b0;
            end else begin
                run(1);
            end
        end
        redirect = 1'b0;

        // Reset mid-access with data buffered, then recover at RESET_PC
        ready = 1'b0;
        run(9);
        async_reset();
        run(2);
        rst = 1'b0; ready = 1'b1;
        run(12);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
